bitwise_serial_ctrl: RTL and testbench
======================================

Name: bitwise_serial_ctrl

Overview:
Sequencer that runs one instance of the one-bit multi-function logic slice over a WIDTH-bit operand pair, one bit per clock, most-significant bit first.
- Captures operands and opcode on a start handshake.
- Drives the slice and manages the carry/compare chain between bits.
- Applies the final-stage flag inversion.
- Returns the WIDTH-bit result plus a one-bit compare flag.
- Sits between the instruction decoder and the register file on the NAND-only datapath, replacing a WIDTH-wide slice array.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)
CNTW, $clog2(WIDTH), width of the bit-index counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  one clock; reset is asynchronous and active-low
start  in  1  request; sampled only in IDLE
op  in  2  opcode {op1,op0}, captured with start
a  in  WIDTH  operand A, captured with start
b  in  WIDTH  operand B, captured with start
en  in  1  advance enable; 0 freezes RUN
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; result/flag valid
result  out  WIDTH  bitwise result
flag  out  1  compare flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, flag=0.
  - Internal operand registers, counter and chain register are cleared.
  - Reset mid-RUN abandons the operation; no done pulse is produced.
- State machine (IDLE, RUN, DONE):
  - IDLE, start=1: capture a, b, op; cnt=WIDTH-1; chain=0; result=0; go to RUN. start=0: stay in IDLE.
  - RUN, en=1: process bit cnt; shift slice q into result LSB (result={result[WIDTH-2:0],q}); update chain. If cnt==0, go to DONE; else decrement cnt.
  - RUN, en=0: hold all state; busy stays 1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored in RUN and DONE. It is not queued. Operand/op inputs are don't-care outside the accepting edge.
- Latency: with en held 1, done is high in the cycle after the WIDTH-th edge following the accepting edge. Each en=0 cycle adds one cycle.
- result and flag hold their values from DONE until the next accepted start. They are cleared at that accepting edge.
- Slice function per bit, q:
  - op=00: 0
  - op=01: a^b
  - op=10: a&b
  - op=11: a|b
- Chain:
  - op1=0: chain |= (a_i != b_i). Final value is "a != b".
  - op1=1: magnitude compare. chain is set to a_i&~b_i only at the first differing bit, MSB-first. A sticky "decided" bit freezes chain after that. Final value is unsigned a>b.
- flag on entering DONE: chain XOR op0. So:
  - op=00: flag = a!=b
  - op=01: flag = a==b
  - op=10: flag = a>b
  - op=11: flag = a<=b
- Simultaneous start and reset: reset wins.
- en during IDLE or DONE has no effect.

Decomposition:
- Package bitwise_serial_pkg holds:
  - opcode constants OP_NE=2'b00, OP_XOR=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - state encoding IDLE/RUN/DONE
- One sub-module, bitwise_slice: combinational one-bit function.
  - Inputs: op1, op0, a, b, cin, decided.
  - Outputs: q, cout, decided_out.
- The controller registers cout and decided between bits.

Test Plan:
- WIDTH=8, a=0xA5, b=0x3C, op=01, en=1 → busy for 8 cycles; done pulse 8 edges after accept; result=0x99, flag=0.
- Same operands, op=10 → result=0x24, flag=1 (0xA5>0x3C). Same operands, op=11 → result=0xBD, flag=0.
- a=0x3C, b=0xA5, op=10 → result=0x24, flag=0. Then a=b=0x5A, op=00 → result=0x00, flag=0; op=01 → flag=1.
- op=01, a=0xFF, b=0x0F; en=0 for 3 cycles mid-RUN → done delayed by exactly 3 cycles; result=0xF0. start pulsed during RUN/DONE → ignored, no second done.
- rst_n=0 asynchronously at bit 4 of a run → outputs 0 immediately, no done. Next start after release with a=0x01, b=0x02, op=11 → result=0x03, flag=1.

Source files
------------

// File: rtl/bitwise_serial_pkg.sv
// Shared opcode and state definitions for the bit-serial
// logic sequencer and its one-bit slice.
package bitwise_serial_pkg;

   localparam logic [1:0] OP_NE  = 2'b00;
   localparam logic [1:0] OP_XOR = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/bitwise_slice.sv
// One-bit multi-function logic slice with an equality or
// MSB-first magnitude chain stage.
module bitwise_slice
   import bitwise_serial_pkg::*;
(
   input  logic op1,
   input  logic op0,
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic decided,
   output logic q,
   output logic cout,
   output logic decided_out
);

   // bitwise function selected by the opcode
   always_comb begin
      q = 1'b0;
      unique case ({op1, op0})
         OP_NE:   q = 1'b0;
         OP_XOR:  q = a ^ b;
         OP_AND:  q = a & b;
         OP_OR:   q = a | b;
         default: q = 1'b0;
      endcase
   end

   // chain: sticky difference, or first-difference magnitude
   always_comb begin
      cout        = cin;
      decided_out = decided;
      if (!op1) begin
         cout = cin | (a ^ b);
      end else if (!decided && (a ^ b)) begin
         cout        = a & ~b;
         decided_out = 1'b1;
      end
   end

endmodule

// File: rtl/bitwise_serial_ctrl.sv
// Bit-serial sequencer: walks one slice over a WIDTH-bit
// operand pair MSB first, returning result and compare flag.
module bitwise_serial_ctrl
   import bitwise_serial_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [1:0]       op_r;
   logic [CNTW-1:0]  cnt;
   logic             chain;
   logic             decided;
   logic             q;
   logic             cout;
   logic             dec_nxt;
   logic             accept;
   logic             step;
   logic             last;

   assign accept = (state == IDLE) && start;
   assign step   = (state == RUN) && en;
   assign last   = (cnt == '0);

   bitwise_slice u_slice (
      .op1         (op_r[1]),
      .op0         (op_r[0]),
      .a           (a_r[cnt]),
      .b           (b_r[cnt]),
      .cin         (chain),
      .decided     (decided),
      .q           (q),
      .cout        (cout),
      .decided_out (dec_nxt)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next state and status outputs
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (en && last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // operand capture, bit walk, result shift and final flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= '0;
         b_r     <= '0;
         op_r    <= 2'b00;
         cnt     <= '0;
         chain   <= 1'b0;
         decided <= 1'b0;
         result  <= '0;
         flag    <= 1'b0;
      end else if (accept) begin
         a_r     <= a;
         b_r     <= b;
         op_r    <= op;
         cnt     <= CNTW'(WIDTH - 1);
         chain   <= 1'b0;
         decided <= 1'b0;
         result  <= '0;
         flag    <= 1'b0;
      end else if (step) begin
         result  <= {result[WIDTH-2:0], q};
         chain   <= cout;
         decided <= dec_nxt;
         if (last) begin
            flag <= cout ^ op_r[0];
         end else begin
            cnt <= cnt - CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bitwise_serial_ctrl.sv
// Self-checking bench: vector table plus stall, ignored-start
// and mid-run reset sequences, checked through a scoreboard.
module tb_bitwise_serial_ctrl;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [1:0]   vop;
      logic [W-1:0] er;
      logic         ef;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         en;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         flag;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int exp_done = 0;
   logic [W:0] sb[$];
   vec_t tbl[13];

   bitwise_serial_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .en     (en),
      .busy   (busy),
      .done   (done),
      .result (result),
      .flag   (flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // scoreboard: compare every done pulse against the queue
   initial begin
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               check("spurious_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("result", 32'(result), 32'(e[W:1]));
               check("flag", 32'(flag), 32'(e[0]));
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] ta,
                         input logic [W-1:0] tb_,
                         input logic [1:0] top,
                         input logic [W-1:0] er,
                         input logic ef,
                         input int stall,
                         input bit poke);
      int k;
      int busy_n;
      bit seen;
      @(negedge clk);
      a = ta; b = tb_; op = top; start = 1'b1;
      sb.push_back({er, ef});
      exp_done++;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      check("accept_busy", 32'(busy), 1);
      check("accept_clear", 32'({result, flag}), 0);
      k = 0; busy_n = 0; seen = 0;
      while (!seen && k < 40) begin
         if (busy) busy_n++;
         if (stall > 0 && k == 3) en = 1'b0;
         if (stall > 0 && k == 3 + stall) en = 1'b1;
         if (poke && k == 1) begin
            start = 1'b1; a = '0; b = '0; op = 2'b11;
         end
         if (poke && k == 2) start = 1'b0;
         @(negedge clk);
         k++;
         if (done) seen = 1;
      end
      if (!seen) begin
         check("done_timeout", 0, 1);
      end else begin
         check("latency", k, W + stall);
         check("busy_cycles", busy_n, W + stall);
      end
      if (poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", 32'({done, busy}), 0);
      check("result_hold", 32'(result), 32'(er));
      check("flag_hold", 32'(flag), 32'(ef));
   endtask

   initial begin
      tbl[0]  = '{8'hA5, 8'h3C, 2'b01, 8'h99, 1'b0};
      tbl[1]  = '{8'hA5, 8'h3C, 2'b10, 8'h24, 1'b1};
      tbl[2]  = '{8'hA5, 8'h3C, 2'b11, 8'hBD, 1'b0};
      tbl[3]  = '{8'h3C, 8'hA5, 2'b10, 8'h24, 1'b0};
      tbl[4]  = '{8'h5A, 8'h5A, 2'b00, 8'h00, 1'b0};
      tbl[5]  = '{8'h5A, 8'h5A, 2'b01, 8'h00, 1'b1};
      tbl[6]  = '{8'h5A, 8'h5A, 2'b10, 8'h5A, 1'b0};
      tbl[7]  = '{8'h5A, 8'h5A, 2'b11, 8'h5A, 1'b1};
      tbl[8]  = '{8'h00, 8'hFF, 2'b00, 8'h00, 1'b1};
      tbl[9]  = '{8'h80, 8'h7F, 2'b10, 8'h00, 1'b1};
      tbl[10] = '{8'h7F, 8'h80, 2'b11, 8'hFF, 1'b1};
      tbl[11] = '{8'h01, 8'h00, 2'b10, 8'h00, 1'b1};
      tbl[12] = '{8'hFE, 8'hFF, 2'b11, 8'hFF, 1'b1};

      rst_n = 1'b0; start = 1'b0; en = 1'b1;
      op = 2'b00; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_result", 32'(result), 0);
      check("rst_flag", 32'(flag), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_op(tbl[i].va, tbl[i].vb, tbl[i].vop,
                tbl[i].er, tbl[i].ef, 0, 0);

      run_op(8'hFF, 8'h0F, 2'b01, 8'hF0, 1'b0, 3, 1);
      repeat (10) @(negedge clk);
      check("no_extra_done", done_cnt, exp_done);
      check("idle_after_poke", 32'(busy), 0);

      @(negedge clk);
      a = 8'hA5; b = 8'h3C; op = 2'b01; start = 1'b1;
      sb.push_back({8'h99, 1'b0});
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_done", 32'(done), 0);
      check("arst_result", 32'(result), 0);
      check("arst_flag", 32'(flag), 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("no_done_after_rst", done_cnt, exp_done);

      run_op(8'h01, 8'h02, 2'b11, 8'h03, 1'b1, 0, 0);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
